// File: rtl/wb_regfile.sv
// Write-back stage and integer register file.
// Write-back select, a two-port read with same-cycle write-through, and a retired-write counter.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] ALUrslt_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_valid_o,
  output logic [CNT_W-1:0]  wb_count_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_valid;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;

  assign w_wb_data  = MemtoReg_i ? ReadData_i : ALUrslt_i;
  assign w_wb_valid = RegWrite_i && (rd_i != '0);

  // Entry 0 is held at zero: the write enable excludes it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[ADDR_W'(i)] <= '0;
      end
    end else if (w_wb_valid) begin
      r_regs[rd_i] <= w_wb_data;
    end
  end

  // Retired-write counter; wraps silently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (w_wb_valid) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Read ports: x0 forced to zero, then write-through, then array.
  always_comb begin
    w_rs1_data = r_regs[rs1_addr_i];
    if (rs1_addr_i == '0) begin
      w_rs1_data = '0;
    end else if (w_wb_valid && (rd_i == rs1_addr_i)) begin
      w_rs1_data = w_wb_data;
    end
  end

  always_comb begin
    w_rs2_data = r_regs[rs2_addr_i];
    if (rs2_addr_i == '0) begin
      w_rs2_data = '0;
    end else if (w_wb_valid && (rd_i == rs2_addr_i)) begin
      w_rs2_data = w_wb_data;
    end
  end

  assign rs1_data_o = w_rs1_data;
  assign rs2_data_o = w_rs2_data;
  assign wb_data_o  = w_wb_data;
  assign wb_valid_o = w_wb_valid;
  assign wb_count_o = r_count;

endmodule
